// File: rtl/mask_sched_pkg.sv
// Shared types and default geometry for the gesture-mask read scheduler.
//   state_t : scheduler FSM states
//   owner_t : requester that issued a BRAM read
//   tag_t   : per-read tag carried alongside the BRAM latency
package mask_sched_pkg;

  localparam int unsigned DEF_GRID_W = 48;
  localparam int unsigned DEF_GRID_H = 64;
  localparam int unsigned DEF_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic {
    OWN_DISP,
    OWN_BLOB
  } owner_t;

  typedef struct packed {
    logic       valid;
    owner_t     owner;
    logic [5:0] x;
    logic [6:0] y;
  } tag_t;

endpackage

// File: rtl/mask_tag_pipe.sv
// Tag shift register tracking reads through the address register and BRAM.
//   clk_in   : system clock
//   flush_in : synchronous flush, clears every stage
//   tag_in   : tag of the read issued this cycle (valid=0 when none)
//   tag_out  : tag whose BRAM data is on the read-data bus this cycle
module mask_tag_pipe
  import mask_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk_in,
  input  logic flush_in,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_in) begin
    if (flush_in) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/mask_read_scheduler.sv
// Arbitrates the single gesture-mask BRAM read port between the HDMI overlay
// (fixed priority, fixed latency) and the raster blob scan (valid/ready).
//   clk_in, rst_in           : clock, synchronous active-high reset
//   hcount_in, vcount_in     : video counters, scan starts at (TRIG_H, TRIG_V)
//   disp_req_in/x/y          : overlay read request
//   disp_valid_out/pixel_out : overlay result, RD_LATENCY+1 cycles after request
//   blob_*                   : blob pixel stream with valid/ready handshake
//   blob_trigger_out         : pulse at scan start
//   frame_end_out            : pulse after the last blob transfer
//   mask_addr_out/data_in    : BRAM read port
// Build option MASK_SCHED_STATS_EN adds stall_cycles_out and scan_cycles_out.
module mask_read_scheduler
  import mask_sched_pkg::*;
#(
  parameter int unsigned GRID_W     = DEF_GRID_W,
  parameter int unsigned GRID_H     = DEF_GRID_H,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned PIX_W      = 1,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned TRIG_V     = 320,
  parameter int unsigned TRIG_H     = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              disp_req_in,
  input  logic [5:0]        disp_x_in,
  input  logic [6:0]        disp_y_in,
  output logic              disp_valid_out,
  output logic [PIX_W-1:0]  disp_pixel_out,
  input  logic              blob_ready_in,
  output logic              blob_valid_out,
  output logic [PIX_W-1:0]  blob_pixel_out,
  output logic [5:0]        blob_x_out,
  output logic [6:0]        blob_y_out,
  output logic              blob_trigger_out,
  output logic              frame_end_out,
  output logic [ADDR_W-1:0] mask_addr_out,
  input  logic [PIX_W-1:0]  mask_data_in
`ifdef MASK_SCHED_STATS_EN
  ,
  output logic [15:0]       stall_cycles_out,
  output logic [15:0]       scan_cycles_out
`endif
);

  state_t             state_q, state_d;
  logic [5:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic               blob_busy_q, blob_busy_d;
  logic               blob_valid_q, blob_valid_d;
  logic [PIX_W-1:0]   blob_pixel_q, blob_pixel_d;
  logic [5:0]         blob_x_q, blob_x_d;
  logic [6:0]         blob_y_q, blob_y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  tag_t               issue_tag, tail_tag;

  logic trig_hit, xfer, blob_ok, blob_issue, tail_disp, tail_blob, last_xfer;

  assign trig_hit   = (hcount_in == 11'(TRIG_H)) && (vcount_in == 10'(TRIG_V));
  assign xfer       = blob_valid_q && blob_ready_in;
  // At most one blob read in flight, so a returning result always finds the
  // output register free and the scan order is preserved without a FIFO.
  assign blob_ok    = (state_q == SCAN) && !blob_busy_q && (!blob_valid_q || blob_ready_in);
  assign blob_issue = blob_ok && !disp_req_in;
  assign tail_disp  = tail_tag.valid && (tail_tag.owner == OWN_DISP);
  assign tail_blob  = tail_tag.valid && (tail_tag.owner == OWN_BLOB);
  assign last_xfer  = xfer && (blob_x_q == 6'(GRID_W-1)) && (blob_y_q == 7'(GRID_H-1));

  always_comb begin
    issue_tag = '0;
    addr_d    = addr_q;
    if (disp_req_in) begin
      issue_tag.valid = 1'b1;
      issue_tag.owner = OWN_DISP;
      issue_tag.x     = disp_x_in;
      issue_tag.y     = disp_y_in;
      addr_d          = ADDR_W'(disp_y_in) * ADDR_W'(GRID_W) + ADDR_W'(disp_x_in);
    end else if (blob_issue) begin
      issue_tag.valid = 1'b1;
      issue_tag.owner = OWN_BLOB;
      issue_tag.x     = x_q;
      issue_tag.y     = y_q;
      addr_d          = ADDR_W'(y_q) * ADDR_W'(GRID_W) + ADDR_W'(x_q);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (trig_hit) state_d = ARM;
      ARM: begin
        x_d     = '0;
        y_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (blob_issue) begin
          if (x_q == 6'(GRID_W-1)) begin
            x_d = '0;
            if (y_q == 7'(GRID_H-1)) state_d = DRAIN;
            else                     y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 6'd1;
          end
        end
      end
      DRAIN:   if (last_xfer) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blob_busy_d  = blob_busy_q;
    blob_valid_d = blob_valid_q;
    blob_pixel_d = blob_pixel_q;
    blob_x_d     = blob_x_q;
    blob_y_d     = blob_y_q;
    if (blob_issue)     blob_busy_d = 1'b1;
    else if (tail_blob) blob_busy_d = 1'b0;
    if (tail_blob) begin
      blob_valid_d = 1'b1;
      blob_pixel_d = mask_data_in;
      blob_x_d     = tail_tag.x;
      blob_y_d     = tail_tag.y;
    end else if (xfer) begin
      blob_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      blob_busy_q  <= 1'b0;
      blob_valid_q <= 1'b0;
      blob_pixel_q <= '0;
      blob_x_q     <= '0;
      blob_y_q     <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      blob_busy_q  <= blob_busy_d;
      blob_valid_q <= blob_valid_d;
      blob_pixel_q <= blob_pixel_d;
      blob_x_q     <= blob_x_d;
      blob_y_q     <= blob_y_d;
      addr_q       <= addr_d;
    end
  end

  mask_tag_pipe #(
    .DEPTH (RD_LATENCY + 1)
  ) u_tag_pipe (
    .clk_in   (clk_in),
    .flush_in (rst_in),
    .tag_in   (issue_tag),
    .tag_out  (tail_tag)
  );

  assign disp_valid_out   = tail_disp;
  assign disp_pixel_out   = tail_disp ? mask_data_in : '0;
  assign blob_valid_out   = blob_valid_q;
  assign blob_pixel_out   = blob_pixel_q;
  assign blob_x_out       = blob_x_q;
  assign blob_y_out       = blob_y_q;
  assign blob_trigger_out = (state_q == ARM);
  assign frame_end_out    = (state_q == DONE);
  assign mask_addr_out    = addr_q;

`ifdef MASK_SCHED_STATS_EN
  logic [15:0] stall_q, scan_cnt_q, scan_len_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_q    <= '0;
      scan_cnt_q <= '0;
      scan_len_q <= '0;
    end else begin
      if (state_q == ARM)                            stall_q <= '0;
      else if (blob_ok && disp_req_in && stall_q != '1) stall_q <= stall_q + 16'd1;
      if (state_q == ARM) scan_cnt_q <= 16'd1;
      else if ((state_q == SCAN || state_q == DRAIN) && scan_cnt_q != '1)
        scan_cnt_q <= scan_cnt_q + 16'd1;
      if (state_q == DONE) scan_len_q <= scan_cnt_q;
    end
  end

  assign stall_cycles_out = stall_q;
  assign scan_cycles_out  = scan_len_q;
`endif

endmodule
